// File: rtl/reg_updown_counter_pkg.sv
// ---------------------------------------------------------------------------
// reg_updown_counter_pkg
//   Shared types for the up/down counter slice.
//   op_e        : per-cycle operation selected by the counter's next-state logic
//   decode_op() : maps the raw Load/Inc/Dec request lines onto op_e, applying
//                 Load > Inc/Dec > hold priority. Inc and Dec together cancel
//                 out to a hold.
// ---------------------------------------------------------------------------
package reg_updown_counter_pkg;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_LOAD = 2'd1,
        OP_INC  = 2'd2,
        OP_DEC  = 2'd3
    } op_e;

    function automatic op_e decode_op(input logic load, input logic inc, input logic dec);
        op_e op;
        if (load) begin
            op = OP_LOAD;
        end else if (inc && !dec) begin
            op = OP_INC;
        end else if (dec && !inc) begin
            op = OP_DEC;
        end else begin
            op = OP_HOLD;
        end
        return op;
    endfunction

endpackage

// File: rtl/reg_updown_counter_reg.sv
// ---------------------------------------------------------------------------
// reg_n
//   WIDTH-bit register with synchronous active-low reset and load enable.
//   Ports:
//     clk   : clock, rising edge
//     rst_n : synchronous active-low reset, clears q
//     en    : load enable, q takes d on the edge when high
//     d     : data in
//     q     : registered data out
// ---------------------------------------------------------------------------
module reg_n #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_reg <= '0;
        end else if (en) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/reg_updown_counter.sv
// ---------------------------------------------------------------------------
// reg_updown_counter
//   Modulo-MOD up/down counter with parallel load, wrap or saturate limits,
//   and one-cycle Carry/Borrow pulses.
//   Parameters:
//     WIDTH    : count width in bits (1..32)
//     modulus parameter (2..2**WIDTH); count range is 0..MOD-1
//     SATURATE : 0 = wrap at the limits, 1 = hold at the limits
//   Ports:
//     clk    : clock, rising edge
//     rst_n  : synchronous active-low reset (OUT=0, Carry=Borrow=0)
//     Load   : load IN (clamped to MOD-1), highest priority after reset
//     IN     : parallel load value
//     Inc    : count up request
//     Dec    : count down request (Inc and Dec together hold)
//     OUT    : registered count
//     Carry  : registered one-cycle pulse on up-overflow
//     Borrow : registered one-cycle pulse on down-underflow
//     Zero   : high when OUT == 0, decoded from the count register only
// ---------------------------------------------------------------------------
module reg_updown_counter
    import reg_updown_counter_pkg::*;
#(
    parameter int                WIDTH    = 4,
    parameter longint unsigned   MOD      = 10,
    parameter bit                SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Load,
    input  logic [WIDTH-1:0] IN,
    input  logic             Inc,
    input  logic             Dec,
    output logic [WIDTH-1:0] OUT,
    output logic             Carry,
    output logic             Borrow,
    output logic             Zero
);

    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("reg_updown_counter: WIDTH must be in 1..32");
        end
        if (MOD < 2 || MOD > (64'd1 << WIDTH)) begin : g_bad_mod
            $error("reg_updown_counter: MOD must be in 2..2**WIDTH");
        end
    endgenerate

    // Upper count limit, also the clamp value for oversized loads. Computed in
    // 64 bits before truncation so MOD == 2**WIDTH yields all-ones cleanly.
    localparam logic [WIDTH-1:0] LIMIT = WIDTH'(MOD - 64'd1);

    op_e              op;
    logic [WIDTH-1:0] count_next;
    logic             count_en;
    logic             carry_reg,  carry_next;
    logic             borrow_reg, borrow_next;
    logic             in_over;
    logic             at_limit;
    logic             at_zero;

    // Widen IN so the comparison holds even when MOD == 2**WIDTH.
    assign in_over  = (64'(IN) >= MOD);
    assign at_limit = (OUT == LIMIT);
    assign at_zero  = (OUT == '0);

    always_comb begin
        op          = decode_op(Load, Inc, Dec);
        count_next  = OUT;
        count_en    = 1'b0;
        carry_next  = 1'b0;
        borrow_next = 1'b0;
        case (op)
            OP_LOAD: begin
                count_en   = 1'b1;
                count_next = in_over ? LIMIT : IN;
            end
            OP_INC: begin
                count_en = 1'b1;
                if (at_limit) begin
                    carry_next = 1'b1;
                    count_next = SATURATE ? LIMIT : '0;
                end else begin
                    count_next = OUT + 1'b1;
                end
            end
            OP_DEC: begin
                count_en = 1'b1;
                if (at_zero) begin
                    borrow_next = 1'b1;
                    count_next  = SATURATE ? '0 : LIMIT;
                end else begin
                    count_next = OUT - 1'b1;
                end
            end
            default: begin
                count_en = 1'b0;
            end
        endcase
    end

    reg_n #(
        .WIDTH (WIDTH)
    ) u_count_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (count_en),
        .d     (count_next),
        .q     (OUT)
    );

    // Only one of OP_INC/OP_DEC can be active, so the pulses are exclusive.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            carry_reg  <= 1'b0;
            borrow_reg <= 1'b0;
        end else begin
            carry_reg  <= carry_next;
            borrow_reg <= borrow_next;
        end
    end

    assign Carry  = carry_reg;
    assign Borrow = borrow_reg;
    assign Zero   = at_zero;

endmodule

// File: doc/reg_updown_counter.md
REG_UPDOWN_COUNTER -- requirements
Module: reg_updown_counter

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the register/count width in bits (1..32).
REQ-002 Parameter MOD, default 10, SHALL set the count modulus; legal range 2..2**WIDTH.
REQ-003 Parameter SATURATE, default 0, SHALL select wrap (0) or saturate (1) behaviour at the count limits.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be the synchronous, active-low reset.
REQ-006 Load  input  1  SHALL request a parallel load of IN.
REQ-007 IN  input  WIDTH  SHALL carry the parallel load value.
REQ-008 Inc  input  1  SHALL request count up by one.
REQ-009 Dec  input  1  SHALL request count down by one.
REQ-010 OUT  output  WIDTH  SHALL present the registered count value.
REQ-011 Carry  output  1  SHALL pulse for one cycle on up-overflow (wrap or saturate hit).
REQ-012 Borrow  output  1  SHALL pulse for one cycle on down-underflow (wrap or saturate hit).
REQ-013 Zero  output  1  SHALL be high exactly when OUT == 0.

Function
REQ-014 Operation priority per cycle SHALL be: reset > Load > Inc/Dec > hold.
REQ-015 Load SHALL set OUT to IN on the next edge; IN >= MOD SHALL be clamped to MOD-1.
REQ-016 Load SHALL never assert Carry or Borrow, even if Inc/Dec also high.
REQ-017 Inc alone with OUT < MOD-1 SHALL set OUT to OUT+1; Carry/Borrow low.
REQ-018 Dec alone with OUT > 0 SHALL set OUT to OUT-1; Carry/Borrow low.
REQ-019 Inc alone with OUT == MOD-1: SATURATE=0 -> OUT becomes 0; SATURATE=1 -> OUT holds MOD-1; Carry high next cycle in both modes.
REQ-020 Dec alone with OUT == 0: SATURATE=0 -> OUT becomes MOD-1; SATURATE=1 -> OUT holds 0; Borrow high next cycle in both modes.
REQ-021 Inc and Dec both high without Load SHALL hold OUT with Carry/Borrow low.
REQ-022 No request active SHALL hold OUT with Carry/Borrow low.
REQ-023 Latency: every OUT/Carry/Borrow change SHALL be visible one cycle after the requesting edge; no combinational path from inputs to any output.
REQ-024 Carry and Borrow SHALL be registered and never high simultaneously.
REQ-025 Zero SHALL be derived from the OUT register only (may be decoded, no input dependency).
REQ-026 Arithmetic SHALL be unsigned WIDTH-bit; comparisons against MOD-1 SHALL not overflow when MOD == 2**WIDTH.

Reset
REQ-027 rst_n low at a rising edge SHALL set OUT=0, Carry=0, Borrow=0 (Zero=1), overriding any Load/Inc/Dec that cycle.
REQ-028 Reset asserted mid-count SHALL discard the pending operation; counting resumes from 0 on the first edge with rst_n high.
REQ-029 Outputs before the first reset edge are undefined; the bench SHALL not check them.

Structure
REQ-030 No shared package is required; MOD-1 limit and clamp constant SHALL be local parameters of the module.
REQ-031 One sub-module, reg_n (WIDTH-bit register with synchronous active-low reset and load enable), SHALL hold OUT; next-state/flag logic stays in reg_updown_counter.
REQ-032 Parameter legality (MOD range, WIDTH range) SHALL be checked at elaboration and fail on violation.

Verification (WIDTH=4, MOD=10 unless stated)
REQ-033 Reset then Load IN=7 -> OUT=7 next cycle, Zero=0, Carry=Borrow=0.
REQ-034 OUT=9, Inc, SATURATE=0 -> OUT=0, Carry=1 one cycle, then Carry=0 with Zero=1.
REQ-035 OUT=0, Dec, SATURATE=1 -> OUT=0 held, Borrow=1 one cycle; second Dec -> Borrow=1 again.
REQ-036 Load IN=13 with Inc high -> OUT=9, Carry=0; then Inc and Dec together -> OUT stays 9.
REQ-037 Counting up from 3 with Inc, rst_n low on third edge -> OUT=0, Carry=0 despite Inc.
REQ-038 WIDTH=4, MOD=16: OUT=15, Inc -> OUT=0, Carry=1; Dec from 0 -> OUT=15, Borrow=1.
